hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. It generates stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the EX-stage forwarding selects. It also runs a handshake FSM that freezes the pipeline while a multi-cycle data-memory access in MEM completes. It keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_if.sv | 22 ++
 rtl/hazard_ctrl.sv | 57 +++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline stage fields in, stall/flush/forward controls and DRAM handshake out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_wR, MEM_wR, WB_wR;
    logic ID_rs1_used, ID_rs2_used, EX_rf_we, EX_br_taken, MEM_rf_we, MEM_mem_req, WB_rf_we, dram_ack;
    logic [1:0] EX_rf_wsel, MEM_rf_wsel;
    logic dram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic mem_wb_bubble, mem_timeout;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rs1, EX_rs2, EX_wR, EX_rf_we, EX_rf_wsel,
               EX_br_taken, MEM_wR, MEM_rf_we, MEM_rf_wsel, MEM_mem_req, WB_wR, WB_rf_we, dram_ack,
        input  dram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cnt
    );
    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rs1, EX_rs2, EX_wR, EX_rf_we, EX_rf_wsel,
               EX_br_taken, MEM_wR, MEM_rf_we, MEM_rf_wsel, MEM_mem_req, WB_wR, WB_rf_we, dram_ack,
        output dram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forward sequencer with a DRAM wait FSM,
// saturating stall-cycle counter and sticky memory-timeout flag.
module hazard_ctrl #(
    parameter logic [1:0] WSEL_DRAM = 2'b01,
    parameter int          TIMEOUT   = 64,
    parameter int          CNT_W     = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic {IDLE, MEM_WAIT} state_e;
    state_e            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              freeze, load_use, stall;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    always_comb begin
        freeze = (state_q == IDLE && bus.MEM_mem_req) || (state_q == MEM_WAIT && !bus.dram_ack);
        load_use = bus.EX_rf_we && bus.EX_rf_wsel == WSEL_DRAM && bus.EX_wR != 5'd0 &&
                   ((bus.ID_rs1_used && bus.ID_rs1 == bus.EX_wR) || (bus.ID_rs2_used && bus.ID_rs2 == bus.EX_wR));
        // A taken branch makes the ID instruction wrong-path, so its load-use stall is moot.
        stall = freeze || (load_use && !bus.EX_br_taken);
        state_d = state_q == IDLE ? (bus.MEM_mem_req ? MEM_WAIT : IDLE) : (bus.dram_ack ? IDLE : MEM_WAIT);
        wait_d = state_q == IDLE ? '0 : (wait_q == WW'(TIMEOUT - 1) ? wait_q : wait_q + 1'b1);
        timeout_d = timeout_q || (state_q == MEM_WAIT && !bus.dram_ack && wait_q == WW'(TIMEOUT - 1));
        cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    assign bus.dram_req      = state_q == MEM_WAIT;
    assign bus.pc_stall      = stall;
    assign bus.if_id_stall   = stall;
    assign bus.if_id_flush   = !freeze && bus.EX_br_taken;
    assign bus.id_ex_stall   = freeze;
    assign bus.id_ex_flush   = !freeze && (bus.EX_br_taken || load_use);
    assign bus.ex_mem_stall  = freeze;
    assign bus.mem_wb_bubble = freeze;
    assign bus.mem_timeout   = timeout_q;
    assign bus.stall_cnt     = cnt_q;
    // Loads in MEM have no data yet, so only non-DRAM results forward from EX/MEM.
    assign bus.fwd_a = (bus.MEM_rf_we && bus.MEM_wR != 5'd0 && bus.MEM_wR == bus.EX_rs1 && bus.MEM_rf_wsel != WSEL_DRAM) ? 2'b01 :
                       (bus.WB_rf_we && bus.WB_wR != 5'd0 && bus.WB_wR == bus.EX_rs1) ? 2'b10 : 2'b00;
    assign bus.fwd_b = (bus.MEM_rf_we && bus.MEM_wR != 5'd0 && bus.MEM_wR == bus.EX_rs2 && bus.MEM_rf_wsel != WSEL_DRAM) ? 2'b01 :
                       (bus.WB_rf_we && bus.WB_wR != 5'd0 && bus.WB_wR == bus.EX_rs2) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl (CNT_W=4 build so counter saturation is reachable).
module tb_hazard_ctrl;
    logic clk, rst;
    int n_vec = 0, n_bad = 0;
    int n_frz, n_req;
    hazard_ctrl_if #(.CNT_W(4)) bus ();
    hazard_ctrl #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic idle();
        bus.ID_rs1 = 0; bus.ID_rs2 = 0; bus.ID_rs1_used = 0; bus.ID_rs2_used = 0;
        bus.EX_rs1 = 0; bus.EX_rs2 = 0; bus.EX_wR = 0; bus.EX_rf_we = 0; bus.EX_rf_wsel = 0;
        bus.EX_br_taken = 0; bus.MEM_wR = 0; bus.MEM_rf_we = 0; bus.MEM_rf_wsel = 0;
        bus.MEM_mem_req = 0; bus.WB_wR = 0; bus.WB_rf_we = 0; bus.dram_ack = 0;
    endtask
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask
    task automatic lw_use();
        bus.EX_rf_we = 1; bus.EX_rf_wsel = 2'b01; bus.EX_wR = 5;
        bus.ID_rs1 = 5; bus.ID_rs1_used = 1; bus.ID_rs2 = 1; bus.ID_rs2_used = 1;
    endtask
    initial begin
        do_reset();
        chk("rst_dram_req", bus.dram_req, 0);
        chk("rst_timeout", bus.mem_timeout, 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        chk("rst_pc_stall", bus.pc_stall, 0);
        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        lw_use();
        #1;
        chk("lu_pc_stall", bus.pc_stall, 1);
        chk("lu_ifid_stall", bus.if_id_stall, 1);
        chk("lu_idex_flush", bus.id_ex_flush, 1);
        chk("lu_ifid_flush", bus.if_id_flush, 0);
        chk("lu_idex_stall", bus.id_ex_stall, 0);
        tick(1);
        idle();
        #1;
        chk("lu_bubble_stall", bus.pc_stall, 0);
        chk("lu_bubble_flush", bus.id_ex_flush, 0);
        chk("lu_cnt", bus.stall_cnt, 1);
        lw_use(); bus.ID_rs1_used = 0;
        #1;
        chk("lu_unused_rs", bus.pc_stall, 0);
        bus.ID_rs2 = 5; bus.ID_rs2_used = 1;
        #1;
        chk("lu_rs2", bus.pc_stall, 1);
        bus.EX_wR = 0; bus.ID_rs2 = 0;
        #1;
        chk("lu_x0", bus.pc_stall, 0);
        idle();
        // forwarding
        bus.MEM_wR = 3; bus.MEM_rf_we = 1; bus.WB_wR = 3; bus.WB_rf_we = 1; bus.EX_rs1 = 3; bus.EX_rs2 = 7;
        #1;
        chk("fwd_a_mem", bus.fwd_a, 2'b01);
        chk("fwd_b_none", bus.fwd_b, 2'b00);
        bus.MEM_rf_we = 0;
        #1;
        chk("fwd_a_wb", bus.fwd_a, 2'b10);
        bus.MEM_rf_we = 1; bus.MEM_rf_wsel = 2'b01;
        #1;
        chk("fwd_a_memload", bus.fwd_a, 2'b10);
        bus.EX_rs2 = 3;
        #1;
        chk("fwd_b_wb", bus.fwd_b, 2'b10);
        bus.MEM_rf_wsel = 0; bus.MEM_wR = 0; bus.WB_wR = 0; bus.EX_rs1 = 0;
        #1;
        chk("fwd_a_x0", bus.fwd_a, 2'b00);
        idle();
        // DRAM access: request at cycle 0, ack at cycle 4
        do_reset();
        n_frz = 0; n_req = 0;
        bus.MEM_mem_req = 1;
        for (int c = 0; c < 5; c++) begin
            bus.dram_ack = (c == 4);
            #1;
            n_frz += int'(bus.pc_stall);
            n_req += int'(bus.dram_req);
            if (c == 0) chk("acc_req_c0", bus.dram_req, 0);
            if (c == 1) chk("acc_req_c1", bus.dram_req, 1);
            if (c == 2) chk("acc_bubble", bus.mem_wb_bubble, 1);
            if (c == 4) chk("acc_release", bus.ex_mem_stall, 0);
            tick(1);
        end
        idle();
        #1;
        chk("acc_frz_cycles", n_frz, 4);
        chk("acc_req_cycles", n_req, 4);
        chk("acc_cnt", bus.stall_cnt, 4);
        chk("acc_idle", bus.dram_req, 0);
        // branch vs load-use, then under freeze
        do_reset();
        lw_use(); bus.EX_br_taken = 1;
        #1;
        chk("br_ifid_flush", bus.if_id_flush, 1);
        chk("br_idex_flush", bus.id_ex_flush, 1);
        chk("br_pc_stall", bus.pc_stall, 0);
        bus.MEM_mem_req = 1;
        #1;
        chk("brf_ifid_flush", bus.if_id_flush, 0);
        chk("brf_idex_flush", bus.id_ex_flush, 0);
        chk("brf_pc_stall", bus.pc_stall, 1);
        tick(1);
        chk("brw_idex_flush", bus.id_ex_flush, 0);
        chk("brw_idex_stall", bus.id_ex_stall, 1);
        bus.dram_ack = 1;
        #1;
        chk("bra_ifid_flush", bus.if_id_flush, 1);
        tick(1);
        idle();
        // timeout, then reset mid-access
        do_reset();
        bus.MEM_mem_req = 1;
        tick(60);
        chk("to_early", bus.mem_timeout, 0);
        chk("to_wait_req", bus.dram_req, 1);
        tick(10);
        chk("to_set", bus.mem_timeout, 1);
        bus.dram_ack = 1;
        tick(1);
        bus.MEM_mem_req = 0; bus.dram_ack = 0;
        tick(1);
        chk("to_sticky", bus.mem_timeout, 1);
        chk("to_back_idle", bus.dram_req, 0);
        bus.MEM_mem_req = 1;
        tick(2);
        chk("rm_req", bus.dram_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rm_req_drop", bus.dram_req, 0);
        chk("rm_timeout", bus.mem_timeout, 0);
        chk("rm_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0; bus.MEM_mem_req = 0; bus.dram_ack = 1;
        tick(1);
        chk("rm_ack_ign", bus.dram_req, 0);
        chk("rm_ack_stall", bus.pc_stall, 0);
        // counter saturation (4-bit)
        do_reset();
        lw_use();
        tick(14);
        chk("sat_14", bus.stall_cnt, 14);
        tick(4);
        chk("sat_hold", bus.stall_cnt, 4'hF);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
